// File: rtl/ysyx_22040632_imem_resp.sv
// Instruction-memory responder: accepts one fetch at a time, answers after a fixed
// latency with the addressed word or a fault flag, and has a side load port.
module ysyx_22040632_imem_resp #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [63:0]              req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_inst,
  output logic                     resp_err,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [31:0]              wr_data
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  if (LATENCY == 0) begin : g_bad_latency
    $error("ysyx_22040632_imem_resp: LATENCY must be at least 1");
  end

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     addr_q;
  logic            capture, load_resp;
  logic [63:0]     dec_addr, dec_idx;
  logic            dec_err;
  logic [31:0]     inst_d;
  logic            rst_sync_q;
  logic [31:0]     mem [DEPTH];

  // Reset asserts at once but releases on a clock edge, so the FSM leaves reset cleanly.
  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 1'b1;
    else     rst_sync_q <= 1'b0;
  end

  // NOTE: the array has no reset; program contents must survive rst, and a reset
  // would also keep the array from mapping onto a RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // With LATENCY==1 the response is built on the accept edge, so decode the live address.
  always_comb begin
    dec_addr = (state_q == IDLE) ? req_addr : addr_q;
    dec_idx  = (dec_addr - BASE) >> 2;
    dec_err  = (dec_addr[1:0] != 2'b00) || (dec_addr < BASE) || (dec_idx >= 64'(DEPTH));
    inst_d   = dec_err ? 32'h0000_0000 : mem[dec_idx[AW-1:0]];
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    load_resp  = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture = 1'b1;
          cnt_d   = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d   = RESP;
            load_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      // Counter walks LATENCY-1 down to 0, so RESP is entered LATENCY edges after accept.
      WAIT: begin
        if (cnt_q == '0) begin
          state_d   = RESP;
          load_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_sync_q) begin
    if (rst_sync_q) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      resp_inst <= '0;
      resp_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) addr_q <= req_addr;
      if (load_resp) begin
        resp_inst <= inst_d;
        resp_err  <= dec_err;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040632_imem_resp.sv
// Bench for ysyx_22040632_imem_resp: directed scenarios plus random fetches checked
// against a word-array model; a second LATENCY=1 instance covers back-to-back fetches.
module tb_ysyx_22040632_imem_resp;
  localparam logic [63:0] BASE   = 64'h0000_0000_8000_0000;
  localparam int          DEPTH0 = 1024;
  localparam int          L0     = 2;
  localparam int          AW0    = 10;
  localparam int          DEPTH1 = 16;
  localparam int          L1     = 1;
  localparam int          AW1    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           req_valid0 = 1'b0, req_ready0, resp_valid0, resp_ready0 = 1'b0, resp_err0;
  logic [63:0]    req_addr0 = '0;
  logic [31:0]    resp_inst0, wr_data0 = '0;
  logic           wr_en0 = 1'b0;
  logic [AW0-1:0] wr_addr0 = '0;

  logic           req_valid1 = 1'b0, req_ready1, resp_valid1, resp_ready1 = 1'b1, resp_err1;
  logic [63:0]    req_addr1 = '0;
  logic [31:0]    resp_inst1, wr_data1 = '0;
  logic           wr_en1 = 1'b0;
  logic [AW1-1:0] wr_addr1 = '0;

  ysyx_22040632_imem_resp #(.DEPTH(DEPTH0), .BASE(BASE), .LATENCY(L0)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_inst(resp_inst0), .resp_err(resp_err0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0)
  );

  ysyx_22040632_imem_resp #(.DEPTH(DEPTH1), .BASE(BASE), .LATENCY(L1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_inst(resp_inst1), .resp_err(resp_err1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_m [DEPTH0];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: word-granular memory, faults for misaligned / below BASE / past the last word.
  function automatic logic [32:0] ref_fetch(input logic [63:0] a);
    logic [63:0] word;
    if (a % 4 != 0) return {1'b1, 32'h0};
    if (a < BASE)   return {1'b1, 32'h0};
    word = (a - BASE) / 4;
    if (word >= 64'(DEPTH0)) return {1'b1, 32'h0};
    return {1'b0, mem_m[word[AW0-1:0]]};
  endfunction

  task automatic write0(input int idx, input logic [31:0] d);
    wr_en0 = 1'b1; wr_addr0 = AW0'(idx); wr_data0 = d;
    mem_m[idx] = d;
    @(negedge clk);
    wr_en0 = 1'b0;
  endtask

  // One transaction on the LATENCY=2 instance; called and returns at a falling edge.
  // wr_k > 0 commits a load-port write on the wr_k-th rising edge after accept.
  task automatic fetch(input string tag, input logic [63:0] addr, input bit rdy_wait,
                       input int hold, input int wr_k, input int wr_i,
                       input logic [31:0] wr_d, input logic [32:0] exp);
    int lat;
    check({tag, ".idle_ready"}, 64'(req_ready0), 64'd1);
    req_valid0 = 1'b1; req_addr0 = addr; resp_ready0 = rdy_wait;
    @(negedge clk);
    req_valid0 = 1'b0; req_addr0 = '0;
    lat = 0;
    while (!resp_valid0 && lat < 20) begin
      check({tag, ".busy_ready"}, 64'(req_ready0), 64'd0);
      if (lat + 1 == wr_k) begin
        wr_en0 = 1'b1; wr_addr0 = AW0'(wr_i); wr_data0 = wr_d;
      end
      @(negedge clk);
      wr_en0 = 1'b0;
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(L0));
    check({tag, ".inst"}, 64'(resp_inst0), 64'(exp[31:0]));
    check({tag, ".err"}, 64'(resp_err0), 64'(exp[32]));
    resp_ready0 = 1'b0;
    for (int i = 0; i < hold; i++) begin
      req_valid0 = (i % 2 == 0); req_addr0 = BASE + 64'h10;
      @(negedge clk);
      check({tag, ".hold_valid"}, 64'(resp_valid0), 64'd1);
      check({tag, ".hold_inst"}, 64'(resp_inst0), 64'(exp[31:0]));
      check({tag, ".hold_err"}, 64'(resp_err0), 64'(exp[32]));
      check({tag, ".hold_ready"}, 64'(req_ready0), 64'd0);
    end
    req_valid0 = 1'b0; req_addr0 = '0; resp_ready0 = 1'b1;
    @(negedge clk);
    resp_ready0 = 1'b0;
    check({tag, ".done_valid"}, 64'(resp_valid0), 64'd0);
    check({tag, ".done_ready"}, 64'(req_ready0), 64'd1);
  endtask

  initial begin
    logic [63:0] a;
    logic [31:0] d;
    int          mode, w, t, n_acc, n_rsp;
    int          acc_t [2];
    logic [31:0] got_inst [2];
    logic        got_err [2];
    logic [63:0] a1 [2];
    logic        acc, rsp;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.req_ready", 64'(req_ready0), 64'd1);
    check("rst.resp_valid", 64'(resp_valid0), 64'd0);
    check("rst.resp_inst", 64'(resp_inst0), 64'd0);
    check("rst.resp_err", 64'(resp_err0), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Preload the whole array (random filler around the known program words)
    for (int i = 0; i < DEPTH0; i++) begin
      d = (i == 0) ? 32'h0000_0413 : (i == 1) ? 32'h0010_0073 :
          (i == 2) ? 32'hAAAA_AAAA : $urandom();
      write0(i, d);
    end

    // Basic fetch with resp_ready already high, then a long backpressure hold
    fetch("t1", BASE, 1'b1, 0, 0, 0, 32'h0, {1'b0, 32'h0000_0413});
    fetch("t2", BASE + 64'h4, 1'b0, 5, 0, 0, 32'h0, {1'b0, 32'h0010_0073});

    // Faulting addresses
    fetch("t3.misaligned", BASE + 64'h2, 1'b0, 1, 0, 0, 32'h0, {1'b1, 32'h0});
    fetch("t3.below", 64'h0000_0000_7FFF_FFFC, 1'b0, 0, 0, 0, 32'h0, {1'b1, 32'h0});
    fetch("t3.past_end", BASE + 64'(4 * DEPTH0), 1'b1, 0, 0, 0, 32'h0, {1'b1, 32'h0});
    fetch("t3.last_word", BASE + 64'(4 * DEPTH0 - 4), 1'b0, 0, 0, 0, 32'h0,
          ref_fetch(BASE + 64'(4 * DEPTH0 - 4)));

    // Write during the wait is visible; write on the edge entering RESP is not
    fetch("t4.wait_wr", BASE + 64'h8, 1'b0, 0, 1, 2, 32'hBBBB_BBBB, {1'b0, 32'hBBBB_BBBB});
    mem_m[2] = 32'hBBBB_BBBB;
    write0(2, 32'hAAAA_AAAA);
    fetch("t4.edge_wr", BASE + 64'h8, 1'b0, 0, 2, 2, 32'hBBBB_BBBB, {1'b0, 32'hAAAA_AAAA});
    mem_m[2] = 32'hBBBB_BBBB;

    // Reset while waiting drops the transaction and keeps the array
    req_valid0 = 1'b1; req_addr0 = BASE + 64'h8;
    @(negedge clk);
    req_valid0 = 1'b0;
    check("t5.in_wait_ready", 64'(req_ready0), 64'd0);
    rst = 1'b1;
    #1;
    check("t5.rst_ready", 64'(req_ready0), 64'd1);
    check("t5.rst_valid", 64'(resp_valid0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5.no_resp", 64'(resp_valid0), 64'd0);
      check("t5.idle_ready", 64'(req_ready0), 64'd1);
    end
    fetch("t5.after", BASE, 1'b0, 0, 0, 0, 32'h0, {1'b0, 32'h0000_0413});
    fetch("t5.mem2", BASE + 64'h8, 1'b0, 0, 0, 0, 32'h0, ref_fetch(BASE + 64'h8));

    // Random traffic against the model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) write0($urandom_range(0, DEPTH0 - 1), $urandom());
      mode = $urandom_range(0, 7);
      w    = $urandom_range(0, DEPTH0 - 1);
      case (mode)
        0, 1, 2, 3: a = BASE + 64'(w) * 4;
        4:          a = BASE + 64'(w) * 4 + 64'($urandom_range(1, 3));
        5:          a = BASE - 64'(4 * $urandom_range(1, 64));
        6:          a = BASE + 64'(DEPTH0) * 4 + 64'(4 * $urandom_range(0, 64));
        default:    a = {32'($urandom()) | 32'h1, 32'($urandom()) & 32'hFFFF_FFFC};
      endcase
      fetch("rand", a, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0, 0, 32'h0, ref_fetch(a));
    end

    // LATENCY=1 instance: back-to-back fetches with resp_ready tied high
    wr_en1 = 1'b1; wr_addr1 = AW1'(0); wr_data1 = 32'h0000_0413;
    @(negedge clk);
    wr_addr1 = AW1'(1); wr_data1 = 32'h0010_0073;
    @(negedge clk);
    wr_en1 = 1'b0;
    a1[0] = BASE; a1[1] = BASE + 64'h4;
    t = 0; n_acc = 0; n_rsp = 0;
    acc_t[0] = 0; acc_t[1] = 0;
    got_inst[0] = '0; got_inst[1] = '0; got_err[0] = 1'b1; got_err[1] = 1'b1;
    req_valid1 = 1'b1; req_addr1 = a1[0];
    while (n_rsp < 2 && t < 20) begin
      acc = req_valid1 && req_ready1;
      rsp = resp_valid1 && resp_ready1;
      if (rsp) begin
        got_inst[n_rsp] = resp_inst1;
        got_err[n_rsp]  = resp_err1;
        n_rsp++;
      end
      @(negedge clk);
      t++;
      if (acc) begin
        if (n_acc < 2) acc_t[n_acc] = t;
        n_acc++;
        if (n_acc < 2) req_addr1 = a1[n_acc];
        else           req_valid1 = 1'b0;
      end
    end
    req_valid1 = 1'b0;
    check("t6.responses", 64'(n_rsp), 64'd2);
    check("t6.accept_gap", 64'(acc_t[1] - acc_t[0]), 64'd2);
    check("t6.inst0", 64'(got_inst[0]), 64'h0000_0413);
    check("t6.inst1", 64'(got_inst[1]), 64'h0010_0073);
    check("t6.err0", 64'(got_err[0]), 64'd0);
    check("t6.err1", 64'(got_err[1]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
